divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//   Multi-cycle radix-2 restoring integer divider for the RV32 M-extension
//   ops DIV, DIVU, REM and REMU; it is the inverse counterpart of the Booth
//   multiplier. It sits in the ALU beside the multiplier and uses the same
//   start/done contract, so the ALU sequencer drives both blocks identically.
//   Divide-by-zero and signed overflow produce the RISC-V-mandated results
//   without running the iterative loop.
// PARAMETERS
//   XLEN  core_config_pkg::XLEN (32)  operand/result width in bits
// PORTS
//   clk        in   1     core clock, all state updates on the rising edge
//   rst        in   1     synchronous reset, active-high
//   start      in   1     begin division; sampled only in IDLE
//   dividend   in   XLEN  numerator (rs1); sampled in INIT
//   divisor    in   XLEN  denominator (rs2); sampled in INIT
//   signed_op  in   1     1 = DIV/REM (two's complement), 0 = DIVU/REMU
//   quotient   out  XLEN  quotient, for DIV/DIVU
//   remainder  out  XLEN  remainder, for REM/REMU
//   busy       out  1     high in every state except IDLE
//   done       out  1     one-cycle pulse; results valid while done is high
// BEHAVIOUR
// - Reset: one clock edge with rst=1 forces state to IDLE and clears quotient,
//   remainder, done, the counter and the internal registers to 0. Reset
//   aborts a division in progress; the aborted result is never reported.
// - States: IDLE -> INIT -> COMPUTE -> FIXUP -> DONE -> IDLE.
//   INIT -> DONE is the direct path for the special cases below.
// - IDLE: done=0. If start=1, move to INIT.
// - INIT: latch the operands and signed_op.
//   * signed_op=1: register the absolute values of both operands, plus
//     neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
//   * Clear the remainder accumulator, which is XLEN+1 bits wide. Load the
//     quotient shift register with |dividend|. Clear the counter, which is
//     $clog2(XLEN)+1 bits wide.
//   * divisor==0: preload q=all-ones and r=dividend (raw, not negated).
//     Go to DONE.
//   * signed_op=1, dividend=2^(XLEN-1) and divisor=all-ones: preload
//     q=dividend and r=0. Go to DONE.
//   * Otherwise go to COMPUTE.
// - COMPUTE (XLEN cycles, one quotient bit per cycle):
//   * Shift {acc,qreg} left by 1. trial = acc_shifted - {1'b0,|divisor|}.
//   * If trial >= 0: acc=trial and qreg[0]=1. Else keep acc and qreg[0]=0.
//   * counter++. The cycle with counter==XLEN-1 moves the state to FIXUP.
// - FIXUP: q = neg_q ? -qreg : qreg. r = neg_r ? -acc[XLEN-1:0] : acc.
//   Both negations are skipped when signed_op=0.
// - DONE: drive quotient and remainder from the FIXUP or preload values,
//   set done<=1 and move to IDLE. done therefore shows in the cycle after
//   the DONE edge and lasts exactly one cycle.
// - Latency, counted in rising edges after the edge that samples start:
//   * normal path: done is high after edge XLEN+3 (35 for XLEN=32).
//   * special cases: done is high after edge 2.
// - quotient and remainder hold their last values until the next completion.
// - start is ignored while busy. A new start in the same cycle as done is
//   accepted, because the state is IDLE in that cycle.
// - Identities for every non-special case: dividend = q*divisor + r,
//   |r| < |divisor|, and sign(r) = sign(dividend) or r = 0.
// - The divider contains no combinational path from any input to any output.
// TESTING
// 1 DIVU 100/7, signed_op=0 -> q=14, r=2; done high after edge 35, one cycle.
// 2 DIV -7/2 (0xFFFFFFF9/0x2), signed_op=1 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
// 3 DIVU 0xFFFFFFFF/0x10 -> q=0x0FFFFFFF, r=0xF.
//   Same operands with signed_op=1 -> q=0, r=0xFFFFFFFF.
// 4 Divide-by-zero 5/0, both signed_op values -> q=0xFFFFFFFF, r=5;
//   done after edge 2. Overflow 0x80000000/0xFFFFFFFF, signed_op=1 ->
//   q=0x80000000, r=0; done after edge 2.
// 5 Pulse start again while busy with new operands -> ignored; the first
//   result is reported unchanged. Back-to-back start on the done cycle ->
//   the second result arrives 35 edges later.
// 6 Assert rst during COMPUTE at iteration 10 -> the next cycle shows
//   state IDLE, q=r=0, done=0, and no done pulse follows; a new division
//   after reset completes correctly.
//   Random signed/unsigned operand sweep -> results match a reference model.

Source files
------------

// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if
//   Start/done bus between the ALU sequencer and the iterative divider.
//   The same contract is used by the Booth multiplier.
//
//   start      sequencer -> divider  begin a division (sampled in IDLE)
//   dividend   sequencer -> divider  numerator, rs1 (sampled in INIT)
//   divisor    sequencer -> divider  denominator, rs2 (sampled in INIT)
//   signed_op  sequencer -> divider  1 = DIV/REM, 0 = DIVU/REMU
//   quotient   divider -> sequencer  quotient result
//   remainder  divider -> sequencer  remainder result
//   busy       divider -> sequencer  high whenever the divider is not IDLE
//   done       divider -> sequencer  one-cycle pulse, results valid with it
// ---------------------------------------------------------------------------
interface divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            signed_op;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            busy;
    logic            done;

    modport master (
        output start, dividend, divisor, signed_op,
        input  quotient, remainder, busy, done
    );

    modport slave (
        input  start, dividend, divisor, signed_op,
        output quotient, remainder, busy, done
    );
endinterface

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//   Multi-cycle radix-2 restoring divider for RV32 DIV/DIVU/REM/REMU.
//   Signed operations divide magnitudes and fix up signs at the end.
//   Divide-by-zero and signed overflow (MIN_INT / -1) bypass the loop and
//   return the RISC-V defined results two edges after start.
//
//   clk   core clock, rising edge
//   rst   synchronous reset, active-high; aborts any division in progress
//   bus   divider_if.slave: start/operands in, quotient/remainder/busy/done out
// ---------------------------------------------------------------------------
module divider #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_COMPUTE,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [XLEN:0]   acc;        // partial remainder
    logic [XLEN-1:0] qreg;       // dividend shifts out, quotient bits shift in
    logic [XLEN-1:0] dvsr;       // |divisor|
    logic [CNT_W-1:0] cnt;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] q_res;      // staged result, from FIXUP or a preload
    logic [XLEN-1:0] r_res;
    logic [XLEN-1:0] quotient_r;
    logic [XLEN-1:0] remainder_r;
    logic            done_r;

    // Operand decode, only consumed in INIT.
    logic            dvd_neg, dvs_neg;
    logic            div_zero, sgn_ovf;
    logic [XLEN-1:0] abs_dvd, abs_dvs;

    // One restoring step.
    logic [XLEN+1:0] acc_sh;
    logic            no_borrow;
    logic [XLEN:0]   trial;

    always_comb begin
        dvd_neg  = bus.signed_op & bus.dividend[XLEN-1];
        dvs_neg  = bus.signed_op & bus.divisor[XLEN-1];
        abs_dvd  = dvd_neg ? -bus.dividend : bus.dividend;
        abs_dvs  = dvs_neg ? -bus.divisor  : bus.divisor;
        div_zero = (bus.divisor == '0);
        sgn_ovf  = bus.signed_op && (bus.dividend == MIN_INT) && (bus.divisor == '1);

        acc_sh    = {acc, qreg[XLEN-1]};
        // trial >= 0 is the same as the shifted accumulator not being
        // smaller than the divisor magnitude.
        no_borrow = (acc_sh >= {2'b00, dvsr});
        trial     = acc_sh[XLEN:0] - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable written in a combinational block gets a default
    // before the case statement, otherwise an unlisted path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start) state_nxt = S_INIT;
            S_INIT:    state_nxt = (div_zero || sgn_ovf) ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (cnt == CNT_W'(XLEN - 1)) state_nxt = S_FIXUP;
            S_FIXUP:   state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            qreg        <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            q_res       <= '0;
            r_res       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_INIT: begin
                    acc   <= '0;
                    qreg  <= abs_dvd;
                    dvsr  <= abs_dvs;
                    cnt   <= '0;
                    neg_q <= dvd_neg ^ dvs_neg;
                    neg_r <= dvd_neg;
                    if (div_zero) begin
                        // Raw dividend, never negated, for both signednesses.
                        q_res <= '1;
                        r_res <= bus.dividend;
                    end else if (sgn_ovf) begin
                        q_res <= bus.dividend;
                        r_res <= '0;
                    end
                end
                S_COMPUTE: begin
                    if (no_borrow) begin
                        acc  <= trial;
                        qreg <= {qreg[XLEN-2:0], 1'b1};
                    end else begin
                        acc  <= acc_sh[XLEN:0];
                        qreg <= {qreg[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIXUP: begin
                    q_res <= neg_q ? -qreg : qreg;
                    r_res <= neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
                end
                S_DONE: begin
                    quotient_r  <= q_res;
                    remainder_r <= r_res;
                    done_r      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.done      = done_r;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider. A reference model computes quotient,
//   remainder and completion edge from the RISC-V division rules; one compare
//   process checks done/busy/results against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_divider;
    localparam int XLEN = 32;
    localparam int LAT_NORMAL  = XLEN + 3;
    localparam int LAT_SPECIAL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_if #(.XLEN(XLEN)) bus ();
    divider #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          start_edge;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   edge_cnt = 0;
    int   last_due = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: RISC-V M-extension semantics with plain arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic special);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        special = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; special = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; special = 1'b1;
        end else if (s) begin
            q = 32'(sa / sb); r = 32'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // Compare process: done must appear exactly at the predicted edge with the
    // predicted results, busy must track the outstanding operation.
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check("idle_done", {31'b0, bus.done}, 32'd0);
            check("idle_busy", {31'b0, bus.busy}, 32'd0);
        end else begin
            check("busy", {31'b0, bus.busy}, {31'b0, (edge_cnt < exp_q[0].due)});
            if (bus.done) begin
                check("done_edge", 32'(edge_cnt), 32'(exp_q[0].due));
                check("quotient", bus.quotient, exp_q[0].q);
                check("remainder", bus.remainder, exp_q[0].r);
                void'(exp_q.pop_front());
            end else if (edge_cnt >= exp_q[0].due) begin
                check("done_missing", {31'b0, bus.done}, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // after the INIT edge, so operands are held through INIT.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic special;
        model(a, b, s, e.q, e.r, special);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = s;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        e.start_edge = edge_cnt;
        e.due        = edge_cnt + (special ? LAT_SPECIAL : LAT_NORMAL);
        last_due     = e.due;
        exp_q.push_back(e);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bool_loop: for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("wait_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Directed operation with a hand-computed result that also pins the model.
    task automatic run_lit(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] lq, input logic [31:0] lr);
        logic [31:0] mq, mr;
        logic sp;
        model(a, b, s, mq, mr, sp);
        check("model_q", mq, lq);
        check("model_r", mr, lr);
        issue(a, b, s);
        wait_idle();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (edge %0d)", edge_cnt);
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF};
        vecs[3]  = '{32'hFFFF_FFFF,  32'h10,         1'b1, 32'd0,          32'hFFFF_FFFF};
        vecs[4]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
        vecs[5]  = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vecs[8]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[9]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vecs[10] = '{32'hFFFF_FFF8,  32'hFFFF_FFFE,  1'b1, 32'd4,          32'd0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.signed_op = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, including divide-by-zero and overflow shortcuts.
        for (int i = 0; i < 11; i++)
            run_lit(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r);

        // start while busy, with different operands, is ignored.
        run_lit(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10);
        issue(32'd1000, 32'd33, 1'b0);
        bus.dividend = 32'd55;
        bus.divisor  = 32'd3;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Back-to-back: second start on the done cycle.
        issue(32'd200, 32'd9, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (edge_cnt >= last_due) break;
            @(negedge clk);
        end
        issue(32'hFFFF_FFF0, 32'd3, 1'b1);
        wait_idle();

        // Reset after 10 COMPUTE iterations aborts the division.
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_lit(32'd12345, 32'd100, 1'b0, 32'd123, 32'd45);

        // Mixed random sweep against the model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 6 == 5) b = -b;
            issue(a, b, 1'(i % 2));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
